// File: rtl/sseg_arbiter.sv
// Round-robin owner arbitration for the shared seven-segment display, with a
// minimum dwell per owner and a registered display-value mux feeding sseg.in.
module sseg_arbiter #(
   parameter int NREQ = 4,
   parameter int W = 16,
   parameter int DWELL = 10_000_000,
   parameter logic [W-1:0] IDLE_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] data,
   output logic [NREQ-1:0]   gnt,
   output logic [2:0]        owner,
   output logic              busy,
   output logic              switched,
   output logic [W-1:0]      disp_val
);

   localparam int CW = $clog2(DWELL + 1);

   typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

   state_t          state_reg;
   logic [CW-1:0]   dwell_reg;
   logic [2:0]      last_owner_reg;

   logic [W-1:0]    data_arr [NREQ];
   logic [2:0]      pick;
   logic [NREQ-1:0] pick_oh;
   logic [W-1:0]    pick_val;
   logic [W-1:0]    owner_val;
   logic            owner_req;
   logic            others_req;
   logic            dwell_done;
   logic            do_grant;
   logic            go_idle;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign data_arr[gi] = data[gi*W +: W];
   end

   // Larger k is assigned first so the nearest requester after last_owner wins;
   // k == NREQ is last_owner itself, which therefore has the lowest priority.
   always_comb begin
      pick = last_owner_reg;
      for (int k = NREQ; k >= 1; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && ((int'(last_owner_reg) + k) % NREQ) == i)
               pick = 3'(i);
         end
      end
   end

   always_comb begin
      pick_oh   = '0;
      pick_val  = '0;
      owner_val = '0;
      for (int i = 0; i < NREQ; i++) begin
         pick_oh[i] = (pick == 3'(i));
         if (pick_oh[i])
            pick_val = data_arr[i];
         if (gnt[i])
            owner_val = data_arr[i];
      end
   end

   // In IDLE gnt is zero, so owner_req is 0 and the release path doubles as
   // the idle-grant path. A zero counter in HOLD already behaves as OPEN, which
   // makes the hold exactly DWELL cycles long.
   always_comb begin
      owner_req  = |(req & gnt);
      others_req = |(req & ~gnt);
      dwell_done = (state_reg == OPEN) || (dwell_reg == '0);
      do_grant   = 1'b0;
      go_idle    = 1'b0;
      if (!owner_req) begin
         do_grant = |req;
         go_idle  = ~|req;
      end else if (dwell_done) begin
         do_grant = others_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         dwell_reg      <= '0;
         last_owner_reg <= 3'(NREQ - 1);
         gnt            <= '0;
         owner          <= '0;
         busy           <= 1'b0;
         switched       <= 1'b0;
         disp_val       <= IDLE_VAL;
      end else begin
         switched <= do_grant;
         if (do_grant) begin
            state_reg      <= HOLD;
            dwell_reg      <= CW'(DWELL - 1);
            last_owner_reg <= pick;
            gnt            <= pick_oh;
            owner          <= pick;
            busy           <= 1'b1;
            disp_val       <= pick_val;
         end else if (go_idle) begin
            state_reg <= IDLE;
            dwell_reg <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            disp_val  <= IDLE_VAL;
         end else begin
            disp_val <= owner_val;
            if (dwell_done)
               state_reg <= OPEN;
            else
               dwell_reg <= dwell_reg - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sseg_arbiter.sv
// Scoreboard bench for sseg_arbiter: a driver pushes the reference model's
// expected outputs per edge, an independent monitor pops and compares them.
module tb_sseg_arbiter;

   localparam int NREQ = 4;
   localparam int W = 16;
   localparam int DWELL = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] data = '0;
   logic [NREQ-1:0]   gnt;
   logic [2:0]        owner;
   logic              busy;
   logic              switched;
   logic [W-1:0]      disp_val;

   sseg_arbiter #(.NREQ(NREQ), .W(W), .DWELL(DWELL), .IDLE_VAL(16'h0000)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .owner(owner),
      .busy(busy), .switched(switched), .disp_val(disp_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic            busy;
      logic            switched;
      logic [W-1:0]    disp;
      logic [2:0]      owner;
      bit              chk_owner;
   } exp_t;

   exp_t exp_q[$];
   int   n_compared = 0;
   int   n_mismatched = 0;

   // Reference model: who owns the display and for how many cycles.
   int          m_owner = -1;
   int          m_held = 0;
   int          m_last = NREQ - 1;
   logic [W-1:0] data_v [NREQ];

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus at the negedge and queue what the next edge must show.
   task automatic drive(input bit r, input logic [NREQ-1:0] rq);
      exp_t e;
      int   p;
      bit   sw;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if ($urandom_range(3) == 0) data_v[i] = W'($urandom);
         data[i*W +: W] = data_v[i];
      end
      rst = r;
      req = rq;
      sw = 1'b0;
      if (r) begin
         m_owner = -1;
         m_held = 0;
         m_last = NREQ - 1;
      end else if (m_owner < 0 || !rq[m_owner]) begin
         p = rr_pick(rq, m_last);
         m_owner = p;
         m_held = 1;
         if (p >= 0) begin
            m_last = p;
            sw = 1'b1;
         end
      end else if (m_held >= DWELL && (rq & ~(NREQ'(1) << m_owner)) != 0) begin
         p = rr_pick(rq, m_last);
         m_owner = p;
         m_last = p;
         m_held = 1;
         sw = 1'b1;
      end else begin
         m_held++;
      end
      e.gnt = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
      e.busy = (m_owner >= 0);
      e.switched = sw;
      e.disp = (m_owner >= 0) ? data_v[m_owner] : 16'h0000;
      e.owner = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      e.chk_owner = r || (m_owner >= 0);
      exp_q.push_back(e);
      $display("tx t=%0t rst=%0b req=%b exp_gnt=%b exp_sw=%0b exp_disp=%h",
               $time, r, rq, e.gnt, e.switched, e.disp);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("busy", 32'(busy), 32'(e.busy));
            check("switched", 32'(switched), 32'(e.switched));
            check("disp_val", 32'(disp_val), 32'(e.disp));
            if (e.chk_owner) check("owner", 32'(owner), 32'(e.owner));
         end
      end
   end

   initial begin : driver
      logic [NREQ-1:0] rq;
      for (int i = 0; i < NREQ; i++) data_v[i] = '0;
      repeat (3) drive(1'b1, '0);
      repeat (5) drive(1'b0, '0);
      data_v[0] = 16'h1234;
      drive(1'b0, 4'b0001);
      data_v[0] = 16'h5678;
      repeat (3) drive(1'b0, 4'b0001);
      repeat (14) drive(1'b0, 4'b0011);
      repeat (2) drive(1'b0, 4'b0000);
      repeat (2) drive(1'b0, 4'b0101);
      repeat (3) drive(1'b0, 4'b0100);
      repeat (2) drive(1'b0, 4'b0000);
      repeat (22) drive(1'b0, 4'b1111);
      repeat (10) drive(1'b0, 4'b0100);
      drive(1'b0, 4'b1111);
      drive(1'b1, 4'b1111);
      repeat (8) drive(1'b0, 4'b1111);
      rq = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(5) == 0) rq[$urandom_range(NREQ - 1)] ^= 1'b1;
         drive($urandom_range(199) == 0, rq);
      end
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
